// File: rtl/ahb_arb_mux_nm1s.sv
// N-master to 1-slave AHB-Lite arbiter and multiplexer.
// Address phase is muxed combinationally from the selected master; data phase follows the registered data-phase owner.
module ahb_arb_mux_nm1s #(
  parameter int NM = 2,
  parameter int AW = 32,
  parameter int DW = 64,
  parameter int RR = 1
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [NM*AW-1:0] HADDR_M,
  input  logic [NM*2-1:0]  HTRANS_M,
  input  logic [NM-1:0]    HWRITE_M,
  input  logic [NM*3-1:0]  HSIZE_M,
  input  logic [NM-1:0]    HMASTLOCK_M,
  input  logic [NM*DW-1:0] HWDATA_M,
  output logic [NM-1:0]    HREADY_M,
  output logic [NM-1:0]    HRESP_M,
  output logic [DW-1:0]    HRDATA_M,
  output logic [AW-1:0]    HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic             HMASTLOCK,
  output logic [DW-1:0]    HWDATA,
  input  logic             HREADY,
  input  logic             HRESP,
  input  logic [DW-1:0]    HRDATA,
  output logic [2:0]       HMASTER
);

  localparam int IW = (NM > 2) ? $clog2(NM) : 1;

  logic [NM-1:0] req;
  logic [IW-1:0] g, d, p, s, win, cidx;
  logic          d_valid, s_req;
  int            cand;

  always_comb begin
    for (int m = 0; m < NM; m++) req[m] = HTRANS_M[2*m+1];
  end

  // Iterating from the far end keeps the last hit, i.e. the nearest winner.
  always_comb begin
    win  = g;
    cand = 0;
    cidx = '0;
    if (RR != 0) begin
      for (int k = NM; k >= 1; k--) begin
        cand = int'(p) + k;
        if (cand >= NM) cand = cand - NM;
        cidx = IW'(cand);
        if (req[cidx]) win = cidx;
      end
    end else begin
      for (int k = NM - 1; k >= 0; k--) begin
        if (req[IW'(k)]) win = IW'(k);
      end
    end
  end

  // Owner keeps the bus while requesting or locked; reset forces an idle address phase.
  always_comb begin
    s     = g;
    s_req = 1'b0;
    if (!HRESETn) begin
      s_req = 1'b0;
    end else if (req[g] || HMASTLOCK_M[g]) begin
      s_req = req[g];
    end else if (|req) begin
      s     = win;
      s_req = 1'b1;
    end
  end

  always_comb begin
    HADDR     = '0;
    HTRANS    = 2'b00;
    HWRITE    = 1'b0;
    HSIZE     = 3'b000;
    HMASTLOCK = 1'b0;
    if (s_req) begin
      HADDR     = HADDR_M[s*AW +: AW];
      HTRANS    = HTRANS_M[s*2 +: 2];
      HWRITE    = HWRITE_M[s];
      HSIZE     = HSIZE_M[s*3 +: 3];
      HMASTLOCK = HMASTLOCK_M[s];
    end
    HMASTER = 3'(s);
  end

  always_comb begin
    HWDATA = '0;
    if (d_valid) HWDATA = HWDATA_M[d*DW +: DW];
    HRDATA_M = HRDATA;
  end

  // Stalled requesters other than the selected master see wait states.
  always_comb begin
    HREADY_M = '1;
    HRESP_M  = '0;
    for (int m = 0; m < NM; m++) begin
      if ((d_valid && d == IW'(m)) || (s_req && s == IW'(m))) HREADY_M[m] = HREADY;
      else if (req[m] && HRESETn) HREADY_M[m] = 1'b0;
      if (d_valid && d == IW'(m)) HRESP_M[m] = HRESP;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      g       <= '0;
      d       <= '0;
      d_valid <= 1'b0;
      p       <= IW'(NM - 1);
    end else if (HREADY) begin
      g       <= s;
      d       <= s;
      d_valid <= s_req;
      if (s_req) p <= s;
    end
  end

endmodule
